wfifo_wr_arb: RTL and testbench
===============================

# wfifo_wr_arb

Write-side arbiter for the asynchronous FIFO. It shares the single FIFO write port (winc/wdata, qualified by wfull) between NREQ requesters in the wclk domain. Arbitration is round-robin, with optional bounded bursts. A one-entry holding register decouples grant from FIFO acceptance, so no word is lost when wfull rises.

## Interface
- NREQ, 4: number of requesters, 2..8
- DSIZE, 8: data width; equals the FIFO data width
- MAX_BURST, 8: maximum words per grant when bursting, 1..255
- wclk  in  1  write-domain clock
- wrst_n  in  1  reset, synchronous, active-low
- req  in  NREQ  per-requester word-valid
- din  in  NREQ*DSIZE  requester data; requester i occupies bits [i*DSIZE +: DSIZE]
- gnt  out  NREQ  one-hot; word from requester i is captured at this edge
- wfull  in  1  full flag from the FIFO write-address generator
- winc  out  1  FIFO write enable; equals hold_vld & ~wfull
- wdata  out  DSIZE  FIFO write data (holding register)
- owner  out  clog2(NREQ)  index of the requester last or currently granted
- busy  out  1  high while in BURST state

## Operation
- Holding register: hold_vld, hold_data.
  - can_load = ~hold_vld | ~wfull.
  - On a capture, hold_data <= selected din and hold_vld <= 1.
  - Otherwise, if winc, hold_vld <= 0.
- Round-robin pointer ptr.
  - Selected requester = first i with req[i]=1, scanning ptr, ptr+1, ... modulo NREQ.
- State machine:
  - IDLE:
    - If any req and can_load, gnt the selected requester, capture, and set owner <= sel.
    - If burst is enabled and MAX_BURST>1 and the requester is still eligible, go to BURST with cnt <= 1.
    - Otherwise ptr <= sel+1 (mod NREQ).
  - BURST:
    - If req[owner] and can_load, gnt[owner], capture, cnt <= cnt+1.
    - If cnt+1 == MAX_BURST, go to IDLE and set ptr <= owner+1.
    - If req[owner]=0, go to IDLE, set ptr <= owner+1, and issue no grant that cycle.
    - If req[owner]=1 but can_load=0, stall in BURST.
- gnt is combinational from state, req, ptr, hold_vld and wfull. At most one bit is set. No bit is set when can_load=0.
- Requester protocol:
  - Hold req and din stable until gnt.
  - Advance to the next word in the cycle after gnt.
  - Dropping req without gnt is allowed.
- Counter width: 8 bits. Pointer arithmetic wraps modulo NREQ (NREQ-1 → 0).

## Timing
- Reset state:
  - hold_vld 0, so winc 0.
  - wdata 0, gnt 0, owner 0, busy 0.
  - ptr 0, cnt 0, state IDLE.
- Latency: gnt in cycle N → winc in cycle N+1 (if ~wfull) → word written at edge N+1.
- Throughput: one word per cycle while wfull=0.
- Full boundary:
  - The word in hold is held and winc stays 0 while wfull=1.
  - No gnt is issued while hold_vld & wfull.
  - Resumes the cycle after wfull falls.
- Simultaneous winc and capture: hold is replaced and hold_vld stays 1. Back-to-back streaming has no bubbles.
- Reset mid-burst:
  - The held word is discarded and not written.
  - The pointer returns to 0 and the burst is abandoned.
- wfull combinationally follows the FIFO pointer. No combinational path runs from winc to wfull inside this block.

## Configuration
- WFIFO_WR_ARB_BURST_EN
  - Defined: BURST state is used. The owner keeps the port for up to MAX_BURST consecutive words while req[owner] stays high.
  - Undefined: BURST state is never entered, busy is tied to 0, and ptr advances after every grant (strict word-level round-robin). MAX_BURST is ignored.

## Test plan
- Reset:
  - Hold wrst_n=0 for 3 cycles with req=4'b1111.
  - Expect gnt=0, winc=0, wdata=0, owner=0, busy=0.
  - First gnt after release is gnt=4'b0001.
- Round-robin without burst:
  - All four req high, wfull=0.
  - gnt sequence 0001,0010,0100,1000,0001; winc high every cycle from the second.
- Burst (BURST_EN, MAX_BURST=3):
  - req0 and req2 high.
  - Expect requester 0 granted 3 cycles, then requester 2 granted 3 cycles, then requester 0.
  - busy high during bursts.
- Early burst end:
  - req1 drops after 2 grants.
  - Expect IDLE, one cycle with no gnt, ptr=2, next grant to the next requesting index.
- Full backpressure:
  - Raise wfull for 5 cycles with data 8'hA5 in hold.
  - Expect winc=0 and gnt=0 throughout, wdata stays 8'hA5.
  - After wfull falls: winc=1 for 8'hA5, then streaming resumes with no word dropped or duplicated (scoreboard against FIFO contents).
- Reset mid-burst:
  - Assert wrst_n=0 while owner=2 with cnt=2.
  - Expect held word not written, ptr 0, state IDLE.

Source files
------------

// File: rtl/wfifo_wr_arb_if.sv
// Write-port bundle between the requesters, the arbiter and the FIFO write side.
interface wfifo_wr_arb_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned DSIZE = 8
);
  logic [NREQ-1:0]         req;
  logic [NREQ*DSIZE-1:0]   din;
  logic [NREQ-1:0]         gnt;
  logic                    wfull;
  logic                    winc;
  logic [DSIZE-1:0]        wdata;
  logic [$clog2(NREQ)-1:0] owner;
  logic                    busy;

  modport master (output req, din, wfull, input gnt, winc, wdata, owner, busy);
  modport slave  (input req, din, wfull, output gnt, winc, wdata, owner, busy);
endinterface

// File: rtl/wfifo_wr_arb.sv
// Round-robin write-port arbiter with a one-entry holding register in front of the FIFO.
// Bounded bursts are enabled by defining WFIFO_WR_ARB_BURST_EN.
module wfifo_wr_arb #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned DSIZE     = 8,
  parameter int unsigned MAX_BURST = 8
) (
  input logic           wclk,
  input logic           wrst_n,
  wfifo_wr_arb_if.slave bus
);
  localparam int unsigned IW = $clog2(NREQ);
`ifdef WFIFO_WR_ARB_BURST_EN
  localparam bit BurstEn = (MAX_BURST > 1);
`else
  localparam bit BurstEn = 1'b0;
`endif

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             hold_vld_q, hold_vld_d;
  logic [DSIZE-1:0] hold_data_q, hold_data_d;

  logic [IW-1:0]    sel;
  logic [IW-1:0]    cap_idx;
  logic             any_req;
  logic             can_load;
  logic             capture;
  logic             winc;
  logic [NREQ-1:0]  gnt;
  int               idx;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    return (32'(i) == NREQ - 1) ? '0 : IW'(32'(i) + 1);
  endfunction

  assign winc     = hold_vld_q & ~bus.wfull & wrst_n;
  assign can_load = ~hold_vld_q | ~bus.wfull;

  // Scan from the highest offset down so the last hit is the first requester after ptr.
  always_comb begin
    sel     = ptr_q;
    any_req = 1'b0;
    idx     = 0;
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      idx = (int'(ptr_q) + k) % int'(NREQ);
      if (bus.req[idx]) begin
        sel     = IW'(idx);
        any_req = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    gnt     = '0;
    capture = 1'b0;
    cap_idx = sel;
    unique case (state_q)
      StIdle: begin
        if (any_req && can_load) begin
          gnt[sel] = 1'b1;
          capture  = 1'b1;
          cap_idx  = sel;
          owner_d  = sel;
          if (BurstEn) begin
            state_d = StBurst;
            cnt_d   = 8'd1;
          end else begin
            ptr_d = next_idx(sel);
          end
        end
      end
      StBurst: begin
        if (!bus.req[owner_q]) begin
          state_d = StIdle;
          ptr_d   = next_idx(owner_q);
          cnt_d   = '0;
        end else if (can_load) begin
          gnt[owner_q] = 1'b1;
          capture      = 1'b1;
          cap_idx      = owner_q;
          cnt_d        = cnt_q + 8'd1;
          if (cnt_q + 8'd1 == 8'(MAX_BURST)) begin
            state_d = StIdle;
            ptr_d   = next_idx(owner_q);
            cnt_d   = '0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    // No capture while in reset, so a requester never loses a word to it.
    if (!wrst_n) begin
      gnt     = '0;
      capture = 1'b0;
    end
  end

  always_comb begin
    hold_vld_d  = hold_vld_q;
    hold_data_d = hold_data_q;
    if (capture) begin
      hold_data_d = bus.din[cap_idx*DSIZE +: DSIZE];
      hold_vld_d  = 1'b1;
    end else if (winc) begin
      hold_vld_d = 1'b0;
    end
  end

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      owner_q     <= '0;
      cnt_q       <= '0;
      hold_vld_q  <= 1'b0;
      hold_data_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      hold_vld_q  <= hold_vld_d;
      hold_data_q <= hold_data_d;
    end
  end

  assign bus.gnt   = gnt;
  assign bus.winc  = winc;
  assign bus.wdata = hold_data_q;
  assign bus.owner = owner_q;
  assign bus.busy  = BurstEn & (state_q == StBurst);
endmodule

// File: tb/tb_wfifo_wr_arb.sv
// Directed bench for wfifo_wr_arb: vector table plus backpressure and reset sequences.
module tb_wfifo_wr_arb;
`ifdef WFIFO_WR_ARB_BURST_EN
  localparam bit Burst = 1'b1;
`else
  localparam bit Burst = 1'b0;
`endif

  logic wclk;
  logic wrst_n;

  wfifo_wr_arb_if #(.NREQ(4), .DSIZE(8)) bus ();

  wfifo_wr_arb #(
    .NREQ      (4),
    .DSIZE     (8),
    .MAX_BURST (3)
  ) dut (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .bus    (bus)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic       wfull;
    logic [3:0] gnt;
    logic       winc;
    logic [7:0] wdata;
    logic [1:0] owner;
    logic       busy;
  } vec_t;

  vec_t       tbl[$];
  logic [7:0] fifo_q[$];
  int         n_chk;
  int         n_pass;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic add(input logic r, input logic [3:0] q, input logic f, input logic [3:0] g,
                     input logic w, input logic [7:0] d, input logic [1:0] o, input logic b);
    vec_t v;
    v.rst_n = r; v.req = q; v.wfull = f; v.gnt = g;
    v.winc = w; v.wdata = d; v.owner = o; v.busy = b;
    tbl.push_back(v);
  endtask

  int k;
  int full_left;
  int idle;
  bit after_full;

  initial begin
    n_chk = 0;
    n_pass = 0;
    wrst_n = 1'b0;
    bus.req = 4'hF;
    bus.din = 32'h44332211;
    bus.wfull = 1'b0;
    @(posedge wclk); #1;

    // rst, req, wfull | gnt, winc, wdata, owner, busy
    add(0, 4'hF, 0, 4'h0, 0, 8'h00, 0, 0);
    add(0, 4'hF, 0, 4'h0, 0, 8'h00, 0, 0);
    add(0, 4'hF, 0, 4'h0, 0, 8'h00, 0, 0);
`ifdef WFIFO_WR_ARB_BURST_EN
    add(1, 4'h5, 0, 4'h1, 0, 8'h00, 0, 0);
    add(1, 4'h5, 0, 4'h1, 1, 8'h11, 0, 1);
    add(1, 4'h5, 0, 4'h1, 1, 8'h11, 0, 1);
    add(1, 4'h5, 0, 4'h4, 1, 8'h11, 0, 0);
    add(1, 4'h5, 0, 4'h4, 1, 8'h33, 2, 1);
    add(1, 4'h5, 0, 4'h4, 1, 8'h33, 2, 1);
    add(1, 4'h5, 0, 4'h1, 1, 8'h33, 2, 0);
    add(1, 4'h0, 0, 4'h0, 1, 8'h11, 0, 1);
    add(1, 4'h2, 0, 4'h2, 0, 8'h11, 0, 0);
    add(1, 4'h2, 0, 4'h2, 1, 8'h22, 1, 1);
    add(1, 4'h9, 0, 4'h0, 1, 8'h22, 1, 1);
    add(1, 4'hB, 0, 4'h8, 0, 8'h22, 1, 0);
    add(1, 4'h0, 0, 4'h0, 1, 8'h44, 3, 1);
    add(1, 4'h0, 0, 4'h0, 0, 8'h44, 3, 0);
`else
    add(1, 4'hF, 0, 4'h1, 0, 8'h00, 0, 0);
    add(1, 4'hF, 0, 4'h2, 1, 8'h11, 0, 0);
    add(1, 4'hF, 0, 4'h4, 1, 8'h22, 1, 0);
    add(1, 4'hF, 0, 4'h8, 1, 8'h33, 2, 0);
    add(1, 4'hF, 0, 4'h1, 1, 8'h44, 3, 0);
    add(1, 4'h5, 0, 4'h4, 1, 8'h11, 0, 0);
    add(1, 4'h5, 0, 4'h1, 1, 8'h33, 2, 0);
    add(1, 4'h0, 0, 4'h0, 1, 8'h11, 0, 0);
    add(1, 4'h0, 0, 4'h0, 0, 8'h11, 0, 0);
    add(1, 4'h8, 1, 4'h8, 0, 8'h11, 0, 0);
    add(1, 4'h8, 1, 4'h0, 0, 8'h44, 3, 0);
    add(1, 4'h8, 1, 4'h0, 0, 8'h44, 3, 0);
    add(1, 4'h8, 0, 4'h8, 1, 8'h44, 3, 0);
    add(1, 4'h0, 0, 4'h0, 1, 8'h44, 3, 0);
    add(1, 4'h0, 0, 4'h0, 0, 8'h44, 3, 0);
`endif

    for (int i = 0; i < tbl.size(); i++) begin
      wrst_n    = tbl[i].rst_n;
      bus.req   = tbl[i].req;
      bus.wfull = tbl[i].wfull;
      @(negedge wclk);
      chk($sformatf("v%0d gnt", i),   32'(bus.gnt),   32'(tbl[i].gnt));
      chk($sformatf("v%0d winc", i),  32'(bus.winc),  32'(tbl[i].winc));
      chk($sformatf("v%0d wdata", i), 32'(bus.wdata), 32'(tbl[i].wdata));
      chk($sformatf("v%0d owner", i), 32'(bus.owner), 32'(tbl[i].owner));
      chk($sformatf("v%0d busy", i),  32'(bus.busy),  32'(tbl[i].busy));
      @(posedge wclk); #1;
    end

    // Requester 1 streams A3..AA; wfull is held high for 5 cycles once A5 sits in hold.
    fifo_q.delete();
    k = 0;
    full_left = 0;
    idle = 0;
    after_full = 1'b0;
    for (int c = 0; c < 60 && idle < 3; c++) begin
      bus.req        = (k < 8) ? 4'b0010 : 4'b0000;
      bus.din[15:8]  = 8'hA3 + 8'(k);
      bus.wfull      = (full_left > 0);
      @(negedge wclk);
      if (full_left > 0) begin
        chk("full gnt",   32'(bus.gnt),   32'h0);
        chk("full winc",  32'(bus.winc),  32'h0);
        chk("full wdata", 32'(bus.wdata), 32'hA5);
        full_left--;
        if (full_left == 0) after_full = 1'b1;
      end else if (after_full) begin
        chk("resume winc",  32'(bus.winc),  32'h1);
        chk("resume wdata", 32'(bus.wdata), 32'hA5);
        after_full = 1'b0;
      end
      if (bus.winc) fifo_q.push_back(bus.wdata);
      if (bus.gnt[1] && bus.din[15:8] == 8'hA5) full_left = 5;
      if (bus.gnt[1]) k++;
      if (k == 8 && !bus.winc && bus.gnt == 4'h0) idle++;
      @(posedge wclk); #1;
    end
    chk("stream granted all", 32'(k), 32'd8);
    chk("fifo count", 32'(fifo_q.size()), 32'd8);
    for (int j = 0; j < 8; j++) begin
      if (j < fifo_q.size()) chk($sformatf("fifo[%0d]", j), 32'(fifo_q[j]), 32'(8'hA3 + 8'(j)));
    end

    // Reset while requester 2 owns the port with a word in hold.
    bus.din   = 32'h44332211;
    bus.wfull = 1'b0;
    bus.req   = 4'b0100;
    bus.din[23:16] = 8'h5B;
    @(negedge wclk);
    chk("mid gnt1", 32'(bus.gnt),  32'h4);
    chk("mid busy1", 32'(bus.busy), 32'h0);
    @(posedge wclk); #1;
    bus.din[23:16] = 8'h5C;
    @(negedge wclk);
    chk("mid gnt2", 32'(bus.gnt),  32'h4);
    chk("mid busy2", 32'(bus.busy), 32'(Burst));
    @(posedge wclk); #1;
    bus.din[23:16] = 8'h5D;
    wrst_n = 1'b0;
    @(negedge wclk);
    chk("rst gnt",  32'(bus.gnt),  32'h0);
    chk("rst winc", 32'(bus.winc), 32'h0);
    @(posedge wclk); #1;
    @(negedge wclk);
    chk("rst owner", 32'(bus.owner), 32'h0);
    chk("rst wdata", 32'(bus.wdata), 32'h0);
    chk("rst busy",  32'(bus.busy),  32'h0);
    chk("rst winc2", 32'(bus.winc),  32'h0);
    @(posedge wclk); #1;
    wrst_n  = 1'b1;
    bus.req = 4'hF;
    @(negedge wclk);
    chk("post gnt",  32'(bus.gnt),  32'h1);
    chk("post busy", 32'(bus.busy), 32'h0);
    @(posedge wclk); #1;
    bus.req = 4'h0;
    @(negedge wclk);
    chk("post winc",  32'(bus.winc),  32'h1);
    chk("post wdata", 32'(bus.wdata), 32'h11);
    chk("post owner", 32'(bus.owner), 32'h0);
    @(posedge wclk); #1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
